// File: rtl/health_disp_sched_if.sv
// Display scheduler bus: measurement/alarm sources in, display word and status out.
interface health_disp_sched_if;
  logic [2:0]  req;
  logic [23:0] data0;
  logic [23:0] data1;
  logic [23:0] data2;
  logic        alarm_req;
  logic [23:0] alarm_data;
  logic [1:0]  grant;
  logic [23:0] disp_data;
  logic [5:0]  disp_blank;
  logic        disp_upd;
  logic        idle;

  // Source side: supplies requests and digit words, observes the display.
  modport master (
    output req, data0, data1, data2, alarm_req, alarm_data,
    input  grant, disp_data, disp_blank, disp_upd, idle
  );

  // Scheduler side.
  modport slave (
    input  req, data0, data1, data2, alarm_req, alarm_data,
    output grant, disp_data, disp_blank, disp_upd, idle
  );
endinterface

// File: rtl/health_disp_sched.sv
// Round-robin display scheduler for three measurement sources with a blinking
// alarm override. All outputs are registered; timers run off a 1 ms prescaler.
module health_disp_sched #(
  parameter int CNT_1MS  = 50000,
  parameter int DWELL_MS = 2000,
  parameter int BLINK_MS = 250
) (
  input logic                sys_clk,
  input logic                sys_rst,
  health_disp_sched_if.slave bus
);
  localparam int PRE_W  = $clog2(CNT_1MS + 1);
  localparam int MS_MAX = (DWELL_MS > BLINK_MS) ? DWELL_MS : BLINK_MS;
  localparam int MS_W   = $clog2(MS_MAX + 1);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CNT_1MS - 1);
  localparam logic [MS_W-1:0]  DWELL_LAST = MS_W'(DWELL_MS - 1);
  localparam logic [MS_W-1:0]  BLINK_LAST = MS_W'(BLINK_MS - 1);
  localparam logic [23:0]      DASHES     = 24'hAAAAAA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  // Round-robin search starting after last_src; the last candidate is last_src
  // itself. Result is {found, source}.
  function automatic logic [2:0] rr_next(input logic [1:0] last_src, input logic [2:0] req_v);
    logic [1:0] cand;
    logic [2:0] res;
    res  = 3'b000;
    cand = last_src;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if ((res[2] == 1'b0) && req_v[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Digit word of a measurement source.
  function automatic logic [23:0] sel_data(input logic [1:0] src, input logic [23:0] d0,
                                           input logic [23:0] d1, input logic [23:0] d2);
    case (src)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      default: return DASHES;
    endcase
  endfunction

  state_t           state, nxt_state;
  logic [1:0]       cur_grant, nxt_grant, last, nxt_last, nxt_src;
  logic [PRE_W-1:0] pre, nxt_pre;
  logic [MS_W-1:0]  ms, nxt_ms, ms_last;
  logic [23:0]      cur_data, nxt_data;
  logic [5:0]       cur_blank, nxt_blank;
  logic             upd, nxt_upd, is_idle, nxt_idle;
  logic [2:0]       pick;
  logic             tick, dwell_exp, blink_exp, timer_clr;

  assign pick      = rr_next(last, bus.req);
  assign tick      = (pre == PRE_LAST);
  assign dwell_exp = tick && (ms == DWELL_LAST);
  assign blink_exp = tick && (ms == BLINK_LAST);
  assign ms_last   = (state == ST_ALARM) ? BLINK_LAST : DWELL_LAST;

  assign bus.grant      = cur_grant;
  assign bus.disp_data  = cur_data;
  assign bus.disp_blank = cur_blank;
  assign bus.disp_upd   = upd;
  assign bus.idle       = is_idle;

  // State, timer and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      cur_grant <= 2'd0;
      last      <= 2'd2;
      pre       <= '0;
      ms        <= '0;
      cur_data  <= DASHES;
      cur_blank <= 6'h00;
      upd       <= 1'b0;
      is_idle   <= 1'b1;
    end else begin
      state     <= nxt_state;
      cur_grant <= nxt_grant;
      last      <= nxt_last;
      pre       <= nxt_pre;
      ms        <= nxt_ms;
      cur_data  <= nxt_data;
      cur_blank <= nxt_blank;
      upd       <= nxt_upd;
      is_idle   <= nxt_idle;
    end
  end

  // Next state and next measurement source, alarm first, then drop, then dwell.
  always_comb begin
    nxt_state = state;
    nxt_src   = cur_grant;
    case (state)
      ST_IDLE: begin
        if (bus.alarm_req) begin
          nxt_state = ST_ALARM;
        end else if (pick[2]) begin
          nxt_state = ST_SHOW;
          nxt_src   = pick[1:0];
        end else begin
          nxt_state = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (bus.alarm_req) begin
          nxt_state = ST_ALARM;
        end else if (!bus.req[cur_grant]) begin
          nxt_state = pick[2] ? ST_SHOW : ST_IDLE;
          nxt_src   = pick[1:0];
        end else if (dwell_exp) begin
          nxt_src   = pick[1:0];
        end else begin
          nxt_state = ST_SHOW;
        end
      end
      ST_ALARM: begin
        if (!bus.alarm_req) begin
          nxt_state = pick[2] ? ST_SHOW : ST_IDLE;
          nxt_src   = pick[1:0];
        end else begin
          nxt_state = ST_ALARM;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
  end

  // Next register values for outputs, pointer and timers.
  always_comb begin
    nxt_grant = 2'd0;
    nxt_last  = last;
    nxt_data  = DASHES;
    nxt_blank = 6'h00;
    case (nxt_state)
      ST_SHOW: begin
        nxt_grant = nxt_src;
        nxt_last  = nxt_src;
        nxt_data  = sel_data(nxt_src, bus.data0, bus.data1, bus.data2);
      end
      ST_ALARM: begin
        nxt_grant = 2'd3;
        nxt_data  = bus.alarm_data;
        if (state != ST_ALARM) begin
          nxt_blank = 6'h00;
        end else if (blink_exp) begin
          nxt_blank = ~cur_blank;
        end else begin
          nxt_blank = cur_blank;
        end
      end
      default: begin
        nxt_grant = 2'd0;
      end
    endcase
    nxt_idle  = (nxt_state == ST_IDLE);
    nxt_upd   = (nxt_grant != cur_grant) || (nxt_idle != is_idle);
    timer_clr = (nxt_state != state) || (nxt_grant != cur_grant);
    if (timer_clr) begin
      nxt_pre = '0;
      nxt_ms  = '0;
    end else if (tick) begin
      nxt_pre = '0;
      nxt_ms  = (ms == ms_last) ? '0 : ms + MS_W'(1);
    end else begin
      nxt_pre = pre + PRE_W'(1);
      nxt_ms  = ms;
    end
  end
endmodule

// File: tb/tb_health_disp_sched.sv
// Scoreboard bench: a cycle-count reference model predicts every output cycle.
module tb_health_disp_sched;
  localparam int CNT = 10, DWELL = 3, BLINK = 2;
  localparam int DW = DWELL * CNT, BL = BLINK * CNT;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  health_disp_sched_if bus ();

  health_disp_sched #(.CNT_1MS(CNT), .DWELL_MS(DWELL), .BLINK_MS(BLINK)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  // mode: 0 idle, 1 showing source g, 2 alarm; el = cycles since the slot began
  typedef struct { int mode; int g; int last; int el; logic [5:0] blank; } mst_t;
  typedef struct { logic [1:0] grant; logic [23:0] data; logic [5:0] blank; logic upd; logic idle; } exp_t;

  mst_t ms;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic int pick(int from, logic [2:0] r);
    for (int k = 1; k <= 3; k++) if (r[(from + k) % 3]) return (from + k) % 3;
    return -1;
  endfunction

  function automatic int shown(mst_t s);
    return (s.mode == 2) ? 3 : ((s.mode == 1) ? s.g : 0);
  endfunction

  function automatic mst_t model_next(mst_t s, logic [2:0] r, logic al);
    mst_t n;
    int p;
    n = s;
    p = pick(s.last, r);
    if (s.mode == 0) begin
      if (al) n.mode = 2;
      else if (p >= 0) begin n.mode = 1; n.g = p; n.last = p; end
    end else if (s.mode == 1) begin
      if (al) n.mode = 2;
      else if (!r[s.g]) begin
        if (p >= 0) begin n.g = p; n.last = p; end
        else n.mode = 0;
      end else if (s.el % DW == DW - 1) begin n.g = p; n.last = p; end
    end else begin
      if (!al) begin
        if (p >= 0) begin n.mode = 1; n.g = p; n.last = p; end
        else n.mode = 0;
      end else if (s.el % BL == BL - 1) n.blank = ~s.blank;
    end
    if (n.mode != 2 || s.mode != 2) n.blank = 6'h00;
    if (n.mode != s.mode || shown(n) != shown(s)) n.el = 0;
    else n.el = s.el + 1;
    return n;
  endfunction

  function automatic exp_t model_out(mst_t o, mst_t n, logic [23:0] d0, logic [23:0] d1,
                                     logic [23:0] d2, logic [23:0] ad);
    exp_t e;
    e.grant = 2'(shown(n));
    e.blank = n.blank;
    e.idle  = (n.mode == 0);
    e.upd   = (shown(n) != shown(o)) || ((n.mode == 0) != (o.mode == 0));
    if (n.mode == 2) e.data = ad;
    else if (n.mode == 0) e.data = 24'hAAAAAA;
    else e.data = (n.g == 0) ? d0 : ((n.g == 1) ? d1 : d2);
    return e;
  endfunction

  function automatic mst_t rst_state();
    mst_t s;
    s.mode = 0; s.g = 0; s.last = 2; s.el = 0; s.blank = 6'h00;
    return s;
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e.grant = 2'd0; e.data = 24'hAAAAAA; e.blank = 6'h00; e.upd = 1'b0; e.idle = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
  endtask

  // Reference model: predicts the outputs that follow each clock edge.
  initial begin
    ms = rst_state();
    forever begin
      @(posedge sys_clk or posedge sys_rst);
      if (sys_rst) begin
        ms = rst_state();
        exp_q.delete();
        exp_q.push_back(rst_exp());
      end else begin
        exp_q.push_back(model_out(ms, model_next(ms, bus.req, bus.alarm_req),
                                  bus.data0, bus.data1, bus.data2, bus.alarm_data));
        ms = model_next(ms, bus.req, bus.alarm_req);
      end
    end
  end

  // Monitor: compares the DUT outputs against the oldest prediction.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("grant", 24'(bus.grant), 24'(mon_e.grant));
        check("disp_data", bus.disp_data, mon_e.data);
        check("disp_blank", 24'(bus.disp_blank), 24'(mon_e.blank));
        check("disp_upd", 24'(bus.disp_upd), 24'(mon_e.upd));
        check("idle", 24'(bus.idle), 24'(mon_e.idle));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: wait expired, required condition never reached", name);
  endtask

  // Stimulus: directed scenarios followed by a randomized run.
  initial begin
    int guard;
    bus.req = 3'b000; bus.alarm_req = 1'b0; bus.alarm_data = 24'hEEEEEE;
    bus.data0 = 24'h000365; bus.data1 = 24'h000072; bus.data2 = 24'h000098;
    cycles(3);
    sys_rst = 1'b0;
    cycles(200);                       // idle with no requests
    bus.req = 3'b111;
    cycles(130);                       // rotation 0,1,2,0
    bus.req = 3'b010;
    cycles(100);                       // single requester held
    bus.req = 3'b000;
    cycles(10);
    bus.req = 3'b111;                  // alarm on the dwell-expiry cycle of grant 1
    guard = 0;
    while (!(ms.mode == 1 && ms.g == 1 && ms.el % DW == DW - 1) && guard < 300) begin
      cycles(1); guard++;
    end
    if (guard >= 300) timeout("wait_grant1_expiry");
    bus.alarm_req = 1'b1;
    cycles(90);
    bus.alarm_req = 1'b0;
    cycles(40);
    bus.req = 3'b101;                  // drop source 0 mid-dwell
    guard = 0;
    while (!(ms.mode == 1 && ms.g == 0 && ms.el == 10) && guard < 300) begin
      cycles(1); guard++;
    end
    if (guard >= 300) timeout("wait_grant0_mid");
    bus.req = 3'b100;
    cycles(40);
    bus.alarm_req = 1'b1;              // reset in the middle of an alarm
    cycles(15);
    #2 sys_rst = 1'b1;
    #1;
    check("async_rst_grant", 24'(bus.grant), 24'd0);
    check("async_rst_data", bus.disp_data, 24'hAAAAAA);
    check("async_rst_blank", 24'(bus.disp_blank), 24'd0);
    check("async_rst_upd", 24'(bus.disp_upd), 24'd0);
    check("async_rst_idle", 24'(bus.idle), 24'd1);
    cycles(3);
    sys_rst = 1'b0; bus.alarm_req = 1'b0; bus.req = 3'b100;
    cycles(40);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) bus.alarm_req = ~bus.alarm_req;
      if ($urandom_range(0, 3) == 0) bus.data0 = 24'($urandom);
      if ($urandom_range(0, 3) == 0) bus.data1 = 24'($urandom);
      if ($urandom_range(0, 3) == 0) bus.data2 = 24'($urandom);
      if ($urandom_range(0, 7) == 0) bus.alarm_data = 24'($urandom);
      cycles(1);
    end
    cycles(2);
    if (n_checks < 15000) begin
      n_checks++;
      $display("FAIL monitor_activity: only %0d comparisons, expected at least 15000", n_checks);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/health_disp_sched.md
# health_disp_sched

Display scheduler for the health board's 6-digit 7-segment display. Three measurement sources (temperature, heart rate, SpO2) and one alarm source share the display. The block time-slices the three sources round-robin with a fixed dwell time, lets the alarm pre-empt them with a blinking display, and drives the digit word plus a blank mask into the dynamic-scan/74HC595 display path.

## Interface
Parameters:
- CNT_1MS, 50000: sys_clk cycles per 1 ms tick (50 MHz).
- DWELL_MS, 2000: ms each measurement source stays on the display.
- BLINK_MS, 250: alarm blink half-period in ms.

Ports:
- sys_clk  in  1  system clock. Every register in the block is clocked on its rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- req  in  3  req[i] high means source i has valid data to show.
- data0, data1, data2  in  24 each  source digit words, 6 nibbles. Nibble 5 (bits 23:20) is the leftmost digit. Codes 0–9 are digits; 4'hA is a dash.
- alarm_req  in  1  alarm active (level).
- alarm_data  in  24  alarm digit word.
- grant  out  2  source on display: 0–2 are measurement sources, 3 is the alarm.
- disp_data  out  24  digit word to the display path.
- disp_blank  out  6  per-digit blank mask. 1 means the digit is off.
- disp_upd  out  1  one-cycle pulse when grant changes or the block enters or leaves idle.
- idle  out  1  high when nothing is shown, i.e. dashes.

## Operation
- All outputs are registered.
- Reset values: grant=0, disp_data=24'hAAAAAA, disp_blank=0, disp_upd=0, idle=1. The state is IDLE and the round-robin pointer last=2, so source 0 is searched first.

Timers:
- A prescaler counts 0..CNT_1MS-1 and emits tick_ms on its last count.
- It is cleared to 0 on every grant change and on every state change.
- The dwell counter counts tick_ms in 0..DWELL_MS-1 and is cleared with the prescaler.

Round-robin select ("next"):
- Search the sources in order last+1, last+2, last+3 (mod 3), and take the first one with req set.
- The current source is eligible only as the last candidate.
- If no req bit is set, the result is IDLE.

States:
- IDLE:
  - disp_data=24'hAAAAAA, idle=1, disp_blank=0.
  - alarm_req goes to ALARM.
  - Otherwise, any req bit set goes to SHOW with the "next" source. last is updated to that source.
- SHOW (grant=g):
  - disp_data is data_g, re-registered every cycle (live pass-through).
  - Priority, evaluated each cycle:
    1. alarm_req: go to ALARM. last is unchanged.
    2. req[g] dropped: go to "next" source, or IDLE if none.
    3. Dwell expiry (tick_ms while dwell=DWELL_MS-1): go to "next" source. If g is the only requester, stay on g with timers restarted and disp_upd not pulsed.
- ALARM:
  - grant=3, disp_data=alarm_data (live).
  - Blink phase starts visible on entry (disp_blank=0).
  - The phase toggles every BLINK_MS ticks. Blanked means disp_blank=6'h3F.
  - When alarm_req falls: go to SHOW with the "next" source, or IDLE if none. disp_blank returns to 0 in the same cycle.
- Reset mid-operation returns the block to the reset values immediately (asynchronous). No partial update is emitted.

## Timing
- A decision made in cycle N (from inputs sampled at its edge) updates grant, disp_data, disp_upd and idle at edge N+1.
- Data latency: a change on the granted source's data appears on disp_data 1 cycle later.
- Dwell length: DWELL_MS×CNT_1MS cycles exactly, from grant change to the next grant change.
- Blink length: each phase lasts BLINK_MS×CNT_1MS cycles.
- Alarm pre-emption takes 1 cycle from alarm_req rising to grant=3.
- disp_upd is high for exactly 1 cycle, aligned with the new grant and disp_data.
- Simultaneous events:
  - Alarm together with dwell expiry: alarm wins and last does not advance.
  - req drop together with dwell expiry: handled as a drop; the result is the same.

## Test plan
Simulation parameters: CNT_1MS=10, DWELL_MS=3, BLINK_MS=2.

1. Reset, then req=3'b000 for 200 cycles -> idle=1, disp_data=24'hAAAAAA, no disp_upd.
2. req=3'b111 with data0=24'h000365, data1=24'h000072, data2=24'h000098 -> grant cycles 0,1,2,0, each held exactly 30 cycles. disp_upd pulses at each change. disp_data matches the granted source.
3. req=3'b010 only -> grant=1 is held indefinitely with no disp_upd after the first. Then drop req[1] -> IDLE 1 cycle later with disp_upd=1.
4. In SHOW grant=1 with req=3'b111, assert alarm_req with alarm_data=24'hEEEEEE on the dwell-expiry cycle -> grant=3 next cycle. disp_blank alternates 0 and 6'h3F every 20 cycles. Release alarm_req -> grant=2, since last stayed 1.
5. Drop req[0] mid-dwell while grant=0 and req=3'b101 -> grant=2 next cycle, and its dwell is a full 30 cycles.
6. Assert sys_rst mid-ALARM -> all outputs take their reset values asynchronously. After release with req=3'b100 -> grant=2.
